div_unit: RTL

Iterative radix-2 integer divider for the EX stage of the pipelined MIPS core, executing DIV/DIVU. It accepts operands from ID/EX, runs one quotient bit per cycle, and delivers quotient (LO) and remainder (HI) to the EX/MEM pipeline register. Its `busy` output feeds the hazard unit, which stalls the front of the pipeline. The pipeline's flush signal drives `cancel`, which aborts an in-flight divide.

---
 rtl/div_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign-corrected quotient (LO) and remainder (HI) registered on completion.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_sr;    // dividend magnitude shifts out as quotient bits shift in
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   part;
  logic             neg_q;
  logic             neg_r;
  logic             div0;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   part_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    shifted   = {part[WIDTH-1:0], q_sr[WIDTH-1]};
    trial     = shifted - {1'b0, b_mag};
    // A borrow into the top bit means the trial subtraction went negative.
    qbit      = ~trial[WIDTH];
    part_next = qbit ? trial : shifted;
    q_next    = {q_sr[WIDTH-2:0], qbit};
    r_mag     = part_next[WIDTH-1:0];
    a_abs     = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    b_abs     = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q_sr      <= '0;
      b_mag     <= '0;
      part      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_BUSY;
            cnt   <= '0;
            q_sr  <= a_abs;
            b_mag <= b_abs;
            part  <= '0;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
            div0  <= (divisor == '0);
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          q_sr <= q_next;
          part <= part_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            // With a zero divisor every trial succeeds, so r_mag is the dividend magnitude.
            if (div0)
              quotient <= '1;
            else
              quotient <= neg_q ? (~q_next + 1'b1) : q_next;
            remainder <= neg_r ? (~r_mag + 1'b1) : r_mag;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
